// File: rtl/seven_seg_if.sv
// Digit inputs and display drive for the four-digit clock display.
// The scanner sits on the slave side; whoever supplies the time uses master.
interface seven_seg_if;
   logic [3:0] min_units;
   logic [2:0] min_tens;
   logic [3:0] hour_units;
   logic [2:0] hour_tens;
   logic [3:0] anode;
   logic [6:0] segments;
   logic       dp;

   modport master (
      output min_units, min_tens, hour_units, hour_tens,
      input  anode, segments, dp
   );

   modport slave (
      input  min_units, min_tens, hour_units, hour_tens,
      output anode, segments, dp
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode HH:MM display with a
// blinking colon dot; a full frame always shows one consistent snapshot.
module seven_seg_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 50000000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   seven_seg_if.slave  bus
);

   localparam int RW = $clog2(REFRESH_DIV + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   logic [RW-1:0] r_refresh_cnt;
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_phase;
   logic [1:0]    r_index;
   logic          r_was_enabled;
   logic [3:0]    r_sh_mu;
   logic [2:0]    r_sh_mt;
   logic [3:0]    r_sh_hu;
   logic [2:0]    r_sh_ht;
   logic [3:0]    r_anode;
   logic [6:0]    r_segments;
   logic          r_dp;

   logic          w_slot_tick;
   logic          w_capture;
   logic [3:0]    w_digit;
   logic          w_in_range;
   logic          w_blank;
   logic [6:0]    w_seg;
   logic [3:0]    w_anode;

   function automatic logic [6:0] seg_encode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   assign w_slot_tick = enable && (r_refresh_cnt == RW'(REFRESH_DIV - 1));
   // Snapshot at frame start (3->0 wrap) or on the first enabled cycle.
   assign w_capture   = enable && (!r_was_enabled || (w_slot_tick && (r_index == 2'd3)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_refresh_cnt <= '0;
         r_index       <= 2'd0;
         r_was_enabled <= 1'b0;
      end else if (!enable) begin
         r_refresh_cnt <= '0;
         r_index       <= 2'd0;
         r_was_enabled <= 1'b0;
      end else begin
         r_was_enabled <= 1'b1;
         if (w_slot_tick) begin
            r_refresh_cnt <= '0;
            r_index       <= r_index + 2'd1;
         end else begin
            r_refresh_cnt <= r_refresh_cnt + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt   <= r_blink_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_mu <= 4'd0;
         r_sh_mt <= 3'd0;
         r_sh_hu <= 4'd0;
         r_sh_ht <= 3'd0;
      end else if (w_capture) begin
         r_sh_mu <= bus.min_units;
         r_sh_mt <= bus.min_tens;
         r_sh_hu <= bus.hour_units;
         r_sh_ht <= bus.hour_tens;
      end
   end

   always_comb begin
      w_digit    = 4'd0;
      w_in_range = 1'b1;
      w_blank    = 1'b0;
      case (r_index)
         2'd0: begin
            w_digit    = r_sh_mu;
            w_in_range = (r_sh_mu <= 4'd9);
         end
         2'd1: begin
            w_digit    = {1'b0, r_sh_mt};
            w_in_range = (r_sh_mt <= 3'd5);
         end
         2'd2: begin
            w_digit    = r_sh_hu;
            w_in_range = (r_sh_hu <= 4'd9);
         end
         default: begin
            w_digit    = {1'b0, r_sh_ht};
            w_in_range = (r_sh_ht <= 3'd2);
            w_blank    = BLANK_LZ && (r_sh_ht == 3'd0);
         end
      endcase
      w_seg   = w_in_range ? seg_encode(w_digit) : SEG_DASH;
      w_anode = w_blank ? 4'b1111 : ~(4'b0001 << r_index);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_anode    <= 4'b1111;
         r_segments <= SEG_OFF;
         r_dp       <= 1'b1;
      end else if (!enable) begin
         r_anode    <= 4'b1111;
         r_segments <= SEG_OFF;
         r_dp       <= 1'b1;
      end else begin
         r_anode    <= w_anode;
         r_segments <= w_blank ? SEG_OFF : w_seg;
         r_dp       <= ~((r_index == 2'd2) && r_blink_phase);
      end
   end

   assign bus.anode    = r_anode;
   assign bus.segments = r_segments;
   assign bus.dp       = r_dp;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLINK_DIV=8;
// dut0 blanks a leading hour zero, dut1 does not.
module tb_seven_seg_scanner;

   logic clk;
   logic reset;
   logic enable;
   int   n_vec;
   int   n_miss;
   int   edge_no;

   seven_seg_if bus0 ();
   seven_seg_if bus1 ();

   seven_seg_scanner #(.REFRESH_DIV(4), .BLINK_DIV(8), .BLANK_LZ(1'b1)) dut0 (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus0)
   );

   seven_seg_scanner #(.REFRESH_DIV(4), .BLINK_DIV(8), .BLANK_LZ(1'b0)) dut1 (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "timeout");
   end

   task automatic set_digits(input logic [2:0] ht, input logic [3:0] hu,
                             input logic [2:0] mt, input logic [3:0] mu);
      bus0.hour_tens  = ht;  bus1.hour_tens  = ht;
      bus0.hour_units = hu;  bus1.hour_units = hu;
      bus0.min_tens   = mt;  bus1.min_tens   = mt;
      bus0.min_units  = mu;  bus1.min_units  = mu;
   endtask

   // Edge numbering restarts at each reset release; sample 1 time unit after.
   task automatic go_to(input int k);
      while (edge_no < k) begin
         @(posedge clk);
         #1;
         edge_no++;
      end
   endtask

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_off(input string tag);
      chk({tag, "_anode"}, {3'b000, bus0.anode}, 7'b0001111);
      chk({tag, "_seg"},   bus0.segments,        7'b1111111);
      chk({tag, "_dp"},    {6'd0, bus0.dp},      7'd1);
   endtask

   initial begin
      n_vec   = 0;
      n_miss  = 0;
      edge_no = 0;
      reset   = 1'b1;
      enable  = 1'b1;
      set_digits(3'd1, 4'd2, 3'd3, 4'd4);

      repeat (3) @(posedge clk);
      #1;
      chk_off("reset");
      chk("reset_dut1_anode", {3'b000, bus1.anode}, 7'b0001111);
      reset = 1'b0;

      go_to(1);
      chk("start_anode", {3'b000, bus0.anode}, 7'b0001110);
      go_to(2);
      chk("s0_seg", bus0.segments, 7'b0011001);
      go_to(5);
      chk("s1_anode", {3'b000, bus0.anode}, 7'b0001101);
      chk("s1_seg",   bus0.segments,        7'b0110000);
      chk("s1_dp",    {6'd0, bus0.dp},      7'd1);
      go_to(9);
      chk("s2_anode", {3'b000, bus0.anode}, 7'b0001011);
      chk("s2_seg",   bus0.segments,        7'b0100100);
      chk("s2_dp",    {6'd0, bus0.dp},      7'd0);
      go_to(13);
      chk("s3_anode", {3'b000, bus0.anode}, 7'b0000111);
      chk("s3_seg",   bus0.segments,        7'b1111001);
      chk("s3_dp",    {6'd0, bus0.dp},      7'd1);
      go_to(17);
      chk("f2_s0_anode", {3'b000, bus0.anode}, 7'b0001110);
      chk("f2_s0_seg",   bus0.segments,        7'b0011001);

      // Mid-frame input change: must wait for the next 3->0 capture.
      go_to(18);
      set_digits(3'd0, 4'd2, 3'd3, 4'd7);
      go_to(19);
      chk("hold_mu_seg", bus0.segments, 7'b0011001);
      go_to(29);
      chk("hold_ht_anode", {3'b000, bus0.anode}, 7'b0000111);
      chk("hold_ht_seg",   bus0.segments,        7'b1111001);
      go_to(33);
      chk("new_mu_seg", bus0.segments, 7'b1111000);

      go_to(45);
      chk("blank_anode",      {3'b000, bus0.anode}, 7'b0001111);
      chk("blank_seg",        bus0.segments,        7'b1111111);
      chk("noblank_anode",    {3'b000, bus1.anode}, 7'b0000111);
      chk("noblank_seg",      bus1.segments,        7'b1000000);
      go_to(48);
      chk("blank_end_anode",  {3'b000, bus0.anode}, 7'b0001111);
      go_to(49);
      chk("after_blank_anode", {3'b000, bus0.anode}, 7'b0001110);

      set_digits(3'd0, 4'd2, 3'd6, 4'd12);
      go_to(65);
      chk("dash_mu_seg",   bus0.segments,        7'b0111111);
      chk("dash_mu_anode", {3'b000, bus0.anode}, 7'b0001110);
      go_to(69);
      chk("dash_mt_seg",   bus0.segments,        7'b0111111);

      go_to(70);
      enable = 1'b0;
      set_digits(3'd2, 4'd0, 3'd5, 4'd9);
      go_to(71);
      chk_off("disable");
      go_to(74);
      chk_off("disable_hold");
      enable = 1'b1;
      go_to(75);
      chk("reen_anode", {3'b000, bus0.anode}, 7'b0001110);
      go_to(76);
      chk("reen_mu_seg", bus0.segments, 7'b0010000);
      go_to(79);
      chk("reen_s1_anode", {3'b000, bus0.anode}, 7'b0001101);
      chk("reen_s1_seg",   bus0.segments,        7'b0010010);
      go_to(83);
      chk("reen_s2_anode", {3'b000, bus0.anode}, 7'b0001011);
      chk("reen_s2_seg",   bus0.segments,        7'b1000000);
      chk("reen_s2_dp_phase0", {6'd0, bus0.dp},  7'd1);
      go_to(87);
      chk("reen_s3_anode", {3'b000, bus0.anode}, 7'b0000111);
      chk("reen_s3_seg",   bus0.segments,        7'b0100100);

      // Asynchronous reset mid-frame, then a clean restart.
      go_to(88);
      reset = 1'b1;
      #1;
      chk_off("async_reset");
      @(posedge clk);
      #1;
      reset   = 1'b0;
      edge_no = 0;
      go_to(1);
      chk("rst2_anode",    {3'b000, bus0.anode}, 7'b0001110);
      chk("rst2_zero_seg", bus0.segments,        7'b1000000);
      go_to(2);
      chk("rst2_mu_seg",   bus0.segments,        7'b0010000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
